// File: rtl/counter_req_arbiter.sv
// Shared bounded up/down counter serving NREQ requesters in round-robin order.
// Each granted request is one +1/-1 step that takes exactly three cycles
// (IDLE sample, EXEC update, RESP ack).
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   req[NREQ]        per-requester request, held until ack
//   dir[NREQ]        per-requester direction (1 = up, 0 = down), sampled with req
//   ack[NREQ]        one-cycle one-hot completion pulse
//   err              with ack: 1 = step refused at a bound
//   busy             high while an operation is in flight
//   value[WIDTH]     current counter value
//   grant_idx        index of the requester currently or last served
module counter_req_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned MAXVAL = 1000,
  parameter int unsigned MINVAL = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         dir,
  output logic [NREQ-1:0]         ack,
  output logic                    err,
  output logic                    busy,
  output logic [WIDTH-1:0]        value,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAXVAL);
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MINVAL);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic          dir_q;

  logic          win_found;
  logic [IW-1:0] win_idx;
  int unsigned   cand;

  // Round-robin pick: first set req bit at or above ptr, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(ptr) + k) % NREQ;
      if (!win_found && req[IW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  // Operation sequencer; every output is registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      value     <= MIN_V;
      ack       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      grant_idx <= '0;
      ptr       <= '0;
      dir_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          err <= 1'b0;
          if (win_found) begin
            grant_idx <= win_idx;
            dir_q     <= dir[win_idx];
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          // Saturate at the bounds: a refused step leaves value untouched.
          if (dir_q) begin
            if (value == MAX_V) begin
              err <= 1'b1;
            end else begin
              value <= value + WIDTH'(1);
              err   <= 1'b0;
            end
          end else begin
            if (value == MIN_V) begin
              err <= 1'b1;
            end else begin
              value <= value - WIDTH'(1);
              err   <= 1'b0;
            end
          end
          ack   <= NREQ'(1) << grant_idx;
          state <= RESP;
        end
        RESP: begin
          ack   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
          ptr   <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
          state <= IDLE;
        end
        default: begin
          ack   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_req_arbiter.sv
// Randomised and directed bench for counter_req_arbiter. A schedule-level
// reference (arbitration edges, ack edges, saturating arithmetic) predicts
// every output each cycle.
module tb_counter_req_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned MAXV  = 1000;
  localparam int unsigned MINV  = 0;
  localparam int unsigned IW    = $clog2(NREQ);

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   dir;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic              busy;
  logic [WIDTH-1:0]  value;
  logic [IW-1:0]     grant_idx;

  counter_req_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .MAXVAL(MAXV), .MINVAL(MINV)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .dir(dir), .ack(ack),
    .err(err), .busy(busy), .value(value), .grant_idx(grant_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state, indexed by posedge count.
  int     edge_n = 0;
  bit     m_valid = 0;
  bit     m_pend = 0;
  int     m_arb_edge = 0;
  int     m_ack_edge = 0;
  int     m_next_arb = 0;
  int     m_ptr = 0;
  int     m_gidx = 0;
  bit     m_dir = 0;
  bit     m_err = 0;
  longint m_value = 0;

  logic [NREQ-1:0]  obs_ack;
  logic             obs_err;
  logic             obs_busy;
  logic [WIDTH-1:0] obs_value;

  logic [NREQ-1:0] req_r;
  logic [NREQ-1:0] dir_r;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the reference by one clock edge given the inputs seen at that edge.
  task automatic model_step(input bit rs, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] dr);
    bit found;
    int j;
    edge_n++;
    if (rs) begin
      m_valid = 1; m_pend = 0; m_value = MINV; m_ptr = 0; m_gidx = 0; m_err = 0;
      m_next_arb = edge_n + 1;
      return;
    end
    if (!m_valid) return;
    if (m_pend && edge_n == m_ack_edge) begin
      if (m_dir) begin
        if (m_value == MAXV) m_err = 1; else begin m_value = m_value + 1; m_err = 0; end
      end else begin
        if (m_value == MINV) m_err = 1; else begin m_value = m_value - 1; m_err = 0; end
      end
      m_ptr = (m_gidx + 1) % NREQ;
    end
    if (edge_n >= m_next_arb && rq != '0) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (!found && rq[j]) begin found = 1; m_gidx = j; end
      end
      m_dir = dr[m_gidx];
      m_pend = 1;
      m_arb_edge = edge_n;
      m_ack_edge = edge_n + 1;
      m_next_arb = edge_n + 3;
    end
  endtask

  // One cycle: drive inputs, check outputs at negedge, step reference at posedge.
  task automatic cyc(input bit rs, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] dr);
    logic [NREQ-1:0] e_ack;
    bit in_ack;
    reset = rs; req = rq; dir = dr;
    @(negedge clock);
    obs_ack = ack; obs_err = err; obs_busy = busy; obs_value = value;
    if (m_valid) begin
      in_ack = m_pend && (edge_n == m_ack_edge);
      e_ack  = in_ack ? (NREQ'(1) << m_gidx) : '0;
      check_eq("ack", 64'(ack), 64'(e_ack));
      check_eq("err", 64'(err), 64'(in_ack && m_err));
      check_eq("busy", 64'(busy), 64'(m_pend && (edge_n == m_arb_edge || edge_n == m_ack_edge)));
      check_eq("value", 64'(value), 64'(m_value));
      check_eq("grant_idx", 64'(grant_idx), 64'(m_gidx));
    end
    @(posedge clock);
    model_step(rs, rq, dr);
    #1;
  endtask

  // Single requester holds req for three cycles: sample, EXEC, ack.
  task automatic serve(input int idx, input bit d, input bit exp_err);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    repeat (3) cyc(0, oh, d ? oh : '0);
    check_eq("serve_ack", 64'(obs_ack), 64'(oh));
    check_eq("serve_err", 64'(obs_err), 64'(exp_err));
  endtask

  task automatic rand_run(input int n, input int up_pct, input int rst_permil);
    bit rs;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (obs_ack[i]) req_r[i] = ($urandom_range(0, 3) == 0);
        else if (!req_r[i]) begin
          req_r[i] = ($urandom_range(0, 2) == 0);
          dir_r[i] = ($urandom_range(0, 99) < up_pct);
        end else if ($urandom_range(0, 15) == 0) req_r[i] = 1'b0;
        if ($urandom_range(0, 7) == 0) dir_r[i] = ~dir_r[i];
      end
      rs = ($urandom_range(0, 999) < rst_permil);
      cyc(rs, req_r, dir_r);
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; dir = '0;
    req_r = '0; dir_r = '0; obs_ack = '0;
    @(posedge clock); #1;
    cyc(1, '0, '0);
    cyc(1, '0, '0);

    // Idle after reset.
    repeat (10) cyc(0, '0, '0);
    check_eq("idle_value", 64'(obs_value), 64'(0));
    check_eq("idle_busy", 64'(obs_busy), 64'(0));

    // Single up from requester 1.
    serve(1, 1, 0);
    check_eq("up_value", 64'(obs_value), 64'(1));

    // Down at the lower bound is refused.
    cyc(1, '0, '0);
    serve(2, 0, 1);
    check_eq("min_value", 64'(obs_value), 64'(0));

    // Preload to the upper bound, then one more up is refused.
    repeat (3000) cyc(0, '1, '1);
    check_eq("preload_value", 64'(obs_value), 64'(1000));
    serve(0, 1, 1);
    check_eq("max_value", 64'(obs_value), 64'(1000));

    // All requesters from reset: acks 0,1,2,3,0 every third cycle.
    cyc(1, '0, '0);
    for (int c = 0; c < 15; c++) begin
      cyc(0, '1, '1);
      if (c % 3 == 2) check_eq("rr_order", 64'(obs_ack), 64'(NREQ'(1) << ((c / 3) % NREQ)));
    end
    check_eq("rr_value", 64'(obs_value), 64'(5));
    cyc(0, '0, '0);

    // Pointer wraps after requester 3; req[0] dropped after sampling still acked.
    cyc(1, '0, '0);
    serve(3, 1, 0);
    cyc(0, '1, '1);
    cyc(0, 4'b1110, 4'b1110);
    cyc(0, 4'b1110, 4'b1110);
    check_eq("wrap_ack", 64'(obs_ack), 64'(1));
    check_eq("wrap_value", 64'(obs_value), 64'(2));
    cyc(0, '0, '0);

    // Reset during EXEC aborts the operation.
    cyc(1, '0, '0);
    repeat (7) serve(0, 1, 0);
    check_eq("pre_abort_value", 64'(obs_value), 64'(7));
    cyc(0, 4'b0001, 4'b0001);
    cyc(1, '0, '0);
    check_eq("abort_in_exec", 64'(obs_busy), 64'(1));
    cyc(0, '0, '0);
    check_eq("abort_ack", 64'(obs_ack), 64'(0));
    check_eq("abort_busy", 64'(obs_busy), 64'(0));
    check_eq("abort_value", 64'(obs_value), 64'(0));
    repeat (3) cyc(0, 4'b1001, 4'b1001);
    check_eq("abort_ptr", 64'(obs_ack), 64'(1));
    cyc(0, '0, '0);

    // Randomised traffic near the lower bound, near the upper bound, and with resets.
    cyc(1, '0, '0);
    rand_run(3000, 50, 0);
    cyc(1, '0, '0);
    repeat (3000) cyc(0, '1, '1);
    rand_run(3000, 50, 0);
    rand_run(4000, 50, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
